// File: rtl/latch_wr_sched.sv
// Round-robin scheduler sharing one transparent latch bank between N_REQ writers.
// Drives latch D once per grant, then sequences G through setup/open/hold and acks the owner.
module latch_wr_sched #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned OPEN_CYC  = 1,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ*DW-1:0] i_data,
    input  logic                i_freeze,
    output logic [N_REQ-1:0]    o_gnt,
    output logic [N_REQ-1:0]    o_ack,
    output logic [DW-1:0]       o_lat_d,
    output logic                o_lat_en,
    output logic                o_busy
);
    localparam int unsigned PW      = $clog2(N_REQ);
    localparam int unsigned MAX_SO  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int unsigned CNT_MAX = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StOpen, StHold, StAck} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     own_q, own_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DW-1:0]     lat_d_q, lat_d_d;
    logic              lat_en_q, lat_en_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [PW-1:0]     win_idx;
    logic [DW-1:0]     win_data;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return PW'(sum);
    endfunction

    // First requester at or after the pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && i_req[rr_idx(ptr_q, i)]) begin
                found   = 1'b1;
                win_idx = rr_idx(ptr_q, i);
            end
        end
    end

    assign win_data = i_data[32'(win_idx)*DW +: DW];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        lat_d_d  = lat_d_q;
        lat_en_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found && !i_freeze) begin
                    state_d = StSetup;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    own_d   = win_idx;
                    gnt_d   = N_REQ'(1) << win_idx;
                    lat_d_d = win_data;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d  = StOpen;
                    cnt_d    = CW'(OPEN_CYC - 1);
                    lat_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StOpen: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    lat_en_d = 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StAck;
                    ack_d   = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = (own_q == PW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered busy mirrors the state being entered.
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= '0;
            own_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            lat_d_q  <= '0;
            lat_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            own_q    <= own_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            busy_q   <= busy_d;
        end
    end

    assign o_gnt    = gnt_q;
    assign o_ack    = ack_q;
    assign o_lat_d  = lat_d_q;
    assign o_lat_en = lat_en_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Self-checking bench for latch_wr_sched: cycle tables plus an ack scoreboard
// covering round-robin order, freeze, mid-op reset and non-default timing.
module tb_latch_wr_sched;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] ack;
        logic [W-1:0] lat_d;
        logic         lat_en;
        logic         busy;
    } vec_t;

    typedef struct {
        logic [N-1:0] ack;
        logic [W-1:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]   req, req_t;
    logic [N*W-1:0] data, data_t;
    logic           freeze, freeze_t;
    logic [N-1:0]   gnt, ack, gnt_t, ack_t;
    logic [W-1:0]   lat_d, lat_d_t;
    logic           lat_en, busy, lat_en_t, busy_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pulses = 0;
    logic lat_en_prev = 1'b0;
    sb_t  sb_q[$];
    int   ack_cyc_q[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    latch_wr_sched #(
        .N_REQ(N), .DW(W), .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_freeze(freeze),
        .o_gnt(gnt), .o_ack(ack), .o_lat_d(lat_d), .o_lat_en(lat_en), .o_busy(busy)
    );

    latch_wr_sched #(
        .N_REQ(N), .DW(W), .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)
    ) dut_t (
        .i_clk(clk), .i_rst(rst), .i_req(req_t), .i_data(data_t), .i_freeze(freeze_t),
        .o_gnt(gnt_t), .o_ack(ack_t), .o_lat_d(lat_d_t), .o_lat_en(lat_en_t), .o_busy(busy_t)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] a, input logic [W-1:0] d);
        sb_t e;
        e.ack  = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // One cycle: sample at negedge, score any ack, drop the acked request.
    task automatic step();
        sb_t e;
        @(negedge clk);
        cyc++;
        if (lat_en && !lat_en_prev) pulses++;
        lat_en_prev = lat_en;
        if (ack != '0) begin
            ack_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("ack_owner", 32'(ack), 32'(e.ack));
                check("ack_lat_d", 32'(lat_d), 32'(e.data));
            end
            req = req & ~ack;
        end
    endtask

    task automatic wait_sb_empty(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(sb_q.size()), 32'(0));
    endtask

    task automatic wait_lat_en(input int unsigned budget);
        int unsigned n = 0;
        while (!lat_en && n < budget) begin
            step();
            n++;
        end
        check("lat_en_seen", 32'(lat_en), 32'(1));
    endtask

    initial begin
        // Single write, cycles 1..6 after the request is seen.
        tbl[0] = '{4'b0100, 4'b0000, 8'hA5, 1'b0, 1'b1};
        tbl[1] = '{4'b0100, 4'b0000, 8'hA5, 1'b1, 1'b1};
        tbl[2] = '{4'b0100, 4'b0000, 8'hA5, 1'b0, 1'b1};
        tbl[3] = '{4'b0000, 4'b0100, 8'hA5, 1'b0, 1'b1};
        tbl[4] = '{4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0};
        tbl[5] = '{4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0};

        rst = 1'b1; req = '0; data = '0; freeze = 1'b0;
        req_t = '0; data_t = '0; freeze_t = 1'b0;

        // Reset and idle.
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_outputs", 32'({gnt, ack, lat_d, lat_en, busy}), 32'(0));
        end
        check("idle_outputs_t", 32'({gnt_t, ack_t, lat_d_t, lat_en_t, busy_t}), 32'(0));
        check("idle_no_pulse", 32'(pulses), 32'(0));

        // Single write; data change after grant must not reach the latch.
        data = {8'h44, 8'hA5, 8'h22, 8'h11};
        req  = 4'b0100;
        push(4'b0100, 8'hA5);
        for (int c = 0; c < 6; c++) begin
            step();
            check("sw_gnt", 32'(gnt), 32'(tbl[c].gnt));
            check("sw_ack", 32'(ack), 32'(tbl[c].ack));
            check("sw_lat_d", 32'(lat_d), 32'(tbl[c].lat_d));
            check("sw_lat_en", 32'(lat_en), 32'(tbl[c].lat_en));
            check("sw_busy", 32'(busy), 32'(tbl[c].busy));
            if (c == 0) data[23:16] = 8'h5A;
        end
        check("sw_sb_empty", 32'(sb_q.size()), 32'(0));

        // Round-robin from ptr=0 with back-to-back transactions.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ack_cyc_q.delete();
        data = {8'h40, 8'h30, 8'h20, 8'h10};
        req  = 4'b1111;
        push(4'b0001, 8'h10);
        push(4'b0010, 8'h20);
        push(4'b0100, 8'h30);
        push(4'b1000, 8'h40);
        wait_sb_empty("rr_all_acked", 40);
        check("rr_ack_count", 32'(ack_cyc_q.size()), 32'(4));
        for (int i = 1; i < 4; i++) begin
            check("rr_b2b_period", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'(5));
        end
        req = 4'b1001;
        push(4'b0001, 8'h10);
        push(4'b1000, 8'h40);
        wait_sb_empty("rr_1001_acked", 30);

        // Freeze blocks grants in idle but not an open transaction.
        freeze = 1'b1;
        req    = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            check("frz_no_gnt", 32'({gnt, busy}), 32'(0));
        end
        freeze = 1'b0;
        step();
        check("frz_release_gnt", 32'(gnt), 32'(4'b0010));
        push(4'b0010, 8'h20);
        wait_lat_en(10);
        freeze = 1'b1;
        wait_sb_empty("frz_mid_acked", 20);
        freeze = 1'b0;

        // Mid-op reset: ptr=2 picks requester 2, reset restores ptr=0 priority.
        data = {8'h00, 8'hF0, 8'h00, 8'h0F};
        req  = 4'b0101;
        wait_lat_en(10);
        check("rst_pre_gnt", 32'(gnt), 32'(4'b0100));
        rst = 1'b1;
        step();
        check("rst_lat_en", 32'(lat_en), 32'(0));
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        step();
        check("rst_post_gnt", 32'(gnt), 32'(4'b0001));
        push(4'b0001, 8'h0F);
        push(4'b0100, 8'hF0);
        wait_sb_empty("rst_post_acked", 30);

        // Non-default timing S=2 O=3 H=2 on the second instance.
        data_t = {8'h00, 8'h00, 8'h00, 8'hC3};
        req_t  = 4'b0001;
        for (int c = 1; c <= 9; c++) begin
            step();
            check("t_lat_en", 32'(lat_en_t), 32'((c >= 3 && c <= 5) ? 1 : 0));
            check("t_ack", 32'(ack_t), 32'((c == 8) ? 4'b0001 : 4'b0000));
            check("t_busy", 32'(busy_t), 32'((c <= 8) ? 1 : 0));
            if (c <= 8) check("t_lat_d", 32'(lat_d_t), 32'(8'hC3));
            if (c == 1) check("t_gnt", 32'(gnt_t), 32'(4'b0001));
            if (c == 8) req_t = '0;
        end

        check("lat_en_pulses", 32'(pulses), 32'(11));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
